// File: rtl/score_pkg.sv
// Shared definitions for the menu front end: seven-segment encodings
// (active-low, {g,f,e,d,c,b,a}) and the score conversion state type.
package score_pkg;

    localparam logic [6:0] SEG7_0    = 7'b1000000;
    localparam logic [6:0] SEG7_1    = 7'b1111001;
    localparam logic [6:0] SEG7_2    = 7'b0100100;
    localparam logic [6:0] SEG7_3    = 7'b0110000;
    localparam logic [6:0] SEG7_4    = 7'b0011001;
    localparam logic [6:0] SEG7_5    = 7'b0010010;
    localparam logic [6:0] SEG7_6    = 7'b0000010;
    localparam logic [6:0] SEG7_7    = 7'b1111000;
    localparam logic [6:0] SEG7_8    = 7'b0000000;
    localparam logic [6:0] SEG7_9    = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_UPDATE = 2'd2
    } conv_state_t;

    // Non-decimal nibbles cannot occur after a valid conversion; show blank.
    function automatic logic [6:0] seg7(input logic [3:0] digit);
        case (digit)
            4'd0:    seg7 = SEG7_0;
            4'd1:    seg7 = SEG7_1;
            4'd2:    seg7 = SEG7_2;
            4'd3:    seg7 = SEG7_3;
            4'd4:    seg7 = SEG7_4;
            4'd5:    seg7 = SEG7_5;
            4'd6:    seg7 = SEG7_6;
            4'd7:    seg7 = SEG7_7;
            4'd8:    seg7 = SEG7_8;
            4'd9:    seg7 = SEG7_9;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stability counter and a
// one-cycle pulse when the debounced level falls (active-low press).
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_ff1;
    logic          sync_ff2;
    logic          stable;
    logic [CW-1:0] cnt;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff1 <= 1'b1;
            sync_ff2 <= 1'b1;
        end else begin
            sync_ff1 <= key_raw;
            sync_ff2 <= sync_ff1;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_ff2 != stable) begin
                if (cnt == CNT_LAST) begin
                    stable <= sync_ff2;
                    cnt    <= '0;
                    press  <= ~sync_ff2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/score_menu.sv
// Menu front end for the jump game: debounced run/pause toggle and a
// double-dabble conversion of the high score onto HEX3..HEX0.
//
//  state     | meaning
//  ST_IDLE   | waiting for highscore to differ from the captured value
//  ST_SHIFT  | one add-3/shift iteration per cycle, SCORE_W iterations
//  ST_UPDATE | BCD result complete, load the display registers
module score_menu
    import score_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SCORE_W         = 11
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    input  logic               KEY3,
    input  logic [SCORE_W-1:0] highscore,
    output logic               toggle,
    output logic               busy,
    output logic [6:0]         HEX0,
    output logic [6:0]         HEX1,
    output logic [6:0]         HEX2,
    output logic [6:0]         HEX3
);

    localparam int CW = $clog2(SCORE_W + 1);

    logic               key_press;
    conv_state_t        state;
    logic [SCORE_W-1:0] captured;
    logic [SCORE_W-1:0] bin;
    logic [15:0]        bcd;
    logic [15:0]        bcd_adj;
    logic [CW-1:0]      count;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk    (CLOCK_50),
        .rst_n  (RESET_N),
        .key_raw(KEY3),
        .press  (key_press)
    );

    // Each clean press flips between running and paused.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) toggle <= 1'b0;
        else          toggle <= toggle ^ key_press;
    end

    // Add 3 to every BCD nibble of 5 or more ahead of the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Conversion FSM; the display only changes in ST_UPDATE so it never tears.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= ST_IDLE;
            captured <= '0;
            bin      <= '0;
            bcd      <= '0;
            count    <= '0;
            busy     <= 1'b0;
            HEX0     <= SEG7_0;
            HEX1     <= SEG_BLANK;
            HEX2     <= SEG_BLANK;
            HEX3     <= SEG_BLANK;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (highscore != captured) begin
                        captured <= highscore;
                        bin      <= highscore;
                        bcd      <= '0;
                        busy     <= 1'b1;
                        count    <= CW'(SCORE_W);
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bcd   <= {bcd_adj[14:0], bin[SCORE_W-1]};
                    bin   <= {bin[SCORE_W-2:0], 1'b0};
                    count <= count - 1'b1;
                    if (count == CW'(1)) state <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    HEX0  <= seg7(bcd[3:0]);
                    HEX1  <= (bcd[15:4]  == 12'd0) ? SEG_BLANK : seg7(bcd[7:4]);
                    HEX2  <= (bcd[15:8]  == 8'd0)  ? SEG_BLANK : seg7(bcd[11:8]);
                    HEX3  <= (bcd[15:12] == 4'd0)  ? SEG_BLANK : seg7(bcd[15:12]);
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
